// File: rtl/extend_unit.sv
// extend_unit: immediate/shift-amount extender with a DEPTH-entry output FIFO.
// Ports: CLK/RST (async active-high); in_valid/in_ready/in_data/in_mode accept raw fields;
// out_valid/out_ready/out_data/out_err present the buffered head; err_cnt counts illegal modes.
module extend_unit #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int SHAMT_HI = 15,
  parameter int SHAMT_W  = 5,
  parameter int DEPTH    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [7:0]       err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [OUT_W:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic en, push, pop, bad;
  logic [OUT_W-1:0] zx, sx, res;
  assign zx = OUT_W'(in_data);
  assign sx = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign bad = in_mode[2] & in_mode[1];
  // shifts by 2 only drop sign/zero copies since OUT_W >= IN_W+2
  always_comb
    res = in_mode == 3'd0 ? OUT_W'(in_data[SHAMT_HI -: SHAMT_W]) :
          in_mode == 3'd1 ? zx :
          in_mode == 3'd2 ? sx :
          in_mode == 3'd3 ? {in_data, {(OUT_W-IN_W){1'b0}}} :
          in_mode == 3'd4 ? sx << 2 :
          in_mode == 3'd5 ? zx << 2 : '0;
  // en keeps in_ready low until the first edge after reset releases
  assign in_ready = en && cnt != FULL;
  assign out_valid = cnt != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {out_err, out_data} = mem[rd];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      en <= 1'b0;
      err_cnt <= '0;
    end else begin
      en <= 1'b1;
      if (push) begin
        mem[wr] <= {bad, res};
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (push && bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_extend_unit.sv
// tb_extend_unit: table-driven and scoreboard checks for extend_unit.
module tb_extend_unit;
  logic CLK = 0, RST = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_err;
  logic [15:0] in_data = '0;
  logic [2:0] in_mode = '0;
  logic [31:0] out_data;
  logic [7:0] err_cnt;
  int tests = 0, fails = 0, stalls = 0, outs = 0;
  logic [32:0] q[$];
  typedef struct {logic [15:0] d; logic [2:0] m; logic [31:0] x; logic e;} vec_t;
  vec_t tbl[9];

  extend_unit dut (.CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK)
    if (!RST && out_valid && out_ready) begin
      outs++;
      if (q.size() == 0) check("unexpected_out", {out_err, out_data}, 64'hDEAD);
      else check("out", {out_err, out_data}, q.pop_front());
    end

  task automatic send(input logic [15:0] d, input logic [2:0] m, input logic [32:0] exp);
    logic ok = 0;
    in_data = d; in_mode = m; in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (in_ready) begin ok = 1; break; end
      stalls++;
    end
    if (ok) begin
      q.push_back(exp);
      @(posedge CLK); #1;
    end else check("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge CLK);
    check("drain", q.size(), 0);
    @(posedge CLK); #1;
  endtask

  function automatic logic [32:0] model(input logic [15:0] d, input logic [2:0] m);
    case (m)
      3'd0: return {28'b0, d[15:11]};
      3'd1: return {17'b0, d};
      3'd2: return {1'b0, 32'($signed(d))};
      3'd3: return {1'b0, d, 16'h0};
      3'd4: return {1'b0, 32'($signed(d)) * 32'd4};
      3'd5: return {1'b0, 32'({16'b0, d} * 32'd4)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  initial begin
    int n0, s0;
    tbl[0] = '{16'hF800, 3'd0, 32'h0000001F, 1'b0};
    tbl[1] = '{16'h8004, 3'd1, 32'h00008004, 1'b0};
    tbl[2] = '{16'h8004, 3'd2, 32'hFFFF8004, 1'b0};
    tbl[3] = '{16'h8004, 3'd3, 32'h80040000, 1'b0};
    tbl[4] = '{16'h8004, 3'd4, 32'hFFFE0010, 1'b0};
    tbl[5] = '{16'h8004, 3'd5, 32'h00020010, 1'b0};
    tbl[6] = '{16'hABCD, 3'd6, 32'h00000000, 1'b1};
    tbl[7] = '{16'h7FFF, 3'd7, 32'h00000000, 1'b1};
    tbl[8] = '{16'h7FFF, 3'd2, 32'h00007FFF, 1'b0};
    // reset state
    repeat (2) @(negedge CLK);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", {out_err, out_data}, 0);
    check("rst_err_cnt", err_cnt, 0);
    #3 RST = 0;
    #1 check("in_ready_pre_edge", in_ready, 0);
    @(posedge CLK); #1 check("in_ready_post_edge", in_ready, 1);
    // table: one-cycle latency and all modes
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].d, tbl[i].m, {tbl[i].e, tbl[i].x});
      check("latency_valid", out_valid, 1);
    end
    drain();
    check("err_cnt_2", err_cnt, 2);
    // backpressure with three inputs
    out_ready = 0;
    send(16'h0001, 3'd1, {1'b0, 32'h00000001});
    send(16'hFFFF, 3'd2, {1'b0, 32'hFFFFFFFF});
    in_data = 16'h0010; in_mode = 3'd3; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("full_in_ready", in_ready, 0);
      check("head_stable", {out_valid, out_err, out_data}, {2'b10, 32'h00000001});
    end
    @(posedge CLK); #1 out_ready = 1;
    send(16'h0010, 3'd3, {1'b0, 32'h00100000});
    drain();
    check("bp_err_cnt", err_cnt, 2);
    // continuous streaming
    n0 = outs; s0 = stalls;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] d = 16'($urandom);
      logic [2:0] m = 3'($urandom_range(0, 5));
      send(d, m, model(d, m));
    end
    drain();
    check("stream_count", outs - n0, 10);
    check("stream_stalls", stalls - s0, 0);
    // saturation
    for (int i = 0; i < 300; i++) send(16'($urandom), 3'(6 + i % 2), {1'b1, 32'h0});
    drain();
    check("err_cnt_sat", err_cnt, 255);
    // asynchronous reset with two entries buffered
    out_ready = 0;
    send(16'h1111, 3'd1, 33'h0);
    send(16'h2222, 3'd1, 33'h0);
    #2 RST = 1;
    #1 check("async_out_valid", out_valid, 0);
    check("async_err_cnt", err_cnt, 0);
    check("async_in_ready", in_ready, 0);
    q.delete();
    @(posedge CLK); #1 RST = 0;
    @(posedge CLK); #1 out_ready = 1;
    n0 = outs;
    send(16'hF800, 3'd0, {1'b0, 32'h0000001F});
    drain();
    check("post_rst_count", outs - n0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
